// File: rtl/branch_predictor_pkg.sv
// Shared types for the RV32I direction predictor: fetch word type, 2-bit
// saturating counter encoding and its transition rule.
package branch_predictor_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_INIT = WNT;

    // One step toward the resolved direction, holding at either end.
    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t cur, input logic taken);
        bp_ctr_t nxt;
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute resolution signals between the pipeline (master)
// and the direction predictor (slave).
interface branch_predictor_if #(
    parameter int IDX_BITS = 6
);
    branch_predictor_pkg::rv32i_word lkp_pc;
    logic                            lkp_taken;
    logic [IDX_BITS-1:0]             lkp_idx;
    logic                            upd_valid;
    logic [IDX_BITS-1:0]             upd_idx;
    logic                            upd_taken;
    logic                            upd_pred;
    logic                            mispredict;

    modport master (
        output lkp_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  lkp_taken, lkp_idx, mispredict
    );

    modport slave (
        input  lkp_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output lkp_taken, lkp_idx, mispredict
    );
endinterface

// File: rtl/branch_predictor_sat_ctr2.sv
// One gshare table entry: a 2-bit saturating direction counter that resets
// to weakly-not-taken.
module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    taken,
    output bp_ctr_t state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BP_CTR_INIT;
        end else if (en) begin
            state <= bp_ctr_next(state, taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: PC ^ history indexes a table of 2-bit counters,
// trained non-speculatively at branch resolution, with perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS  = 6,
    parameter int HIST_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_predictor_if.slave    bp,
    output logic [HIST_BITS-1:0] ghr,
    output logic [31:0]          br_cnt,
    output logic [31:0]          mis_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;

    bp_ctr_t ctr [ENTRIES];
    bp_ctr_t lkp_state;
    logic    unused_bits;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic en;
        assign en = bp.upd_valid & (bp.upd_idx == IDX_BITS'(i));
        sat_ctr2 u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .taken (bp.upd_taken),
            .state (ctr[i])
        );
    end

    // No bypass: a lookup colliding with this cycle's update sees the old entry.
    assign bp.lkp_idx   = bp.lkp_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
    assign lkp_state    = ctr[bp.lkp_idx];
    assign bp.lkp_taken = lkp_state[1];
    assign bp.mispredict = bp.upd_valid & (bp.upd_taken ^ bp.upd_pred);

    assign unused_bits = ^{bp.lkp_pc[31:IDX_BITS+2], bp.lkp_pc[1:0], lkp_state[0]};

    // Dropping the oldest bit of {ghr, taken} also covers the 1-bit history case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr     <= '0;
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (bp.upd_valid) begin
                ghr    <= HIST_BITS'({ghr, bp.upd_taken});
                br_cnt <= br_cnt + 32'd1;
            end
            if (bp.mispredict) begin
                mis_cnt <= mis_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic direction predictor for the RV32I pipeline: a gshare table of 2-bit saturating counters, indexed by fetch PC XOR global history. It sits at the opposite end of the branch-comparator path. Fetch queries it for a predicted direction, and execute returns the comparator's resolved `br_en` so the table and history can train. It also flags mispredicts and keeps branch and mispredict performance counters.

## Interface
Parameters:
- `IDX_BITS`, default 6: table has 2^IDX_BITS entries.
- `HIST_BITS`, default 4: global history length. Legal range is 1..IDX_BITS.

Ports:
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `lkp_pc`  in  32  Fetch PC (`rv32i_word`).
- `lkp_taken`  out  1  Predicted direction for `lkp_pc`.
- `lkp_idx`  out  IDX_BITS  Table index used for this lookup. The pipeline carries it to execute.
- `upd_valid`  in  1  A conditional branch resolved this cycle.
- `upd_idx`  in  IDX_BITS  `lkp_idx` that was carried with the resolving branch.
- `upd_taken`  in  1  Resolved direction (comparator `br_en`).
- `upd_pred`  in  1  `lkp_taken` that was carried with the resolving branch.
- `mispredict`  out  1  Resolved direction differs from the prediction.
- `ghr`  out  HIST_BITS  Current global history register.
- `br_cnt`  out  32  Count of resolved branches.
- `mis_cnt`  out  32  Count of mispredicts.

## Operation
- **Index:** `lkp_idx = lkp_pc[IDX_BITS+1:2] ^ zero-extend(ghr)`. PC bits [1:0] are ignored.
- **Lookup:** combinational from current table state. `lkp_taken = table[lkp_idx][1]`.
- **Entry state machine:** each entry is a 2-bit state: SNT=00, WNT=01, WT=10, ST=11.
  - Taken moves the entry up one state (SNT→WNT→WT→ST); ST holds on taken.
  - Not-taken moves it down one state; SNT holds on not-taken.
- **Update:** when `upd_valid`=1, only `table[upd_idx]` transitions. All other entries hold.
- **History:** when `upd_valid`=1, `ghr <= {ghr[HIST_BITS-2:0], upd_taken}`. When HIST_BITS=1, `ghr <= upd_taken`. History is non-speculative: it changes only at resolution.
- **Mispredict:** `mispredict = upd_valid & (upd_taken ^ upd_pred)`. Combinational, same cycle as the update.
- **Performance counters:** when `upd_valid`=1, `br_cnt` += 1. When `mispredict`=1, `mis_cnt` += 1. Both wrap modulo 2^32 and do not saturate.
- **Ignored inputs:** when `upd_valid`=0, `upd_idx`, `upd_taken` and `upd_pred` are don't-care, including X. No state changes.

## Timing
- **Reset:** asserting `rst_n` low immediately sets all entries to WNT, `ghr`=0, `br_cnt`=0 and `mis_cnt`=0. This holds even mid-update: an update in the same cycle as reset is lost.
- **Outputs after reset:** `lkp_taken`=0 and `mispredict`=0 (since `upd_valid` is expected low during reset). `lkp_idx = lkp_pc[IDX_BITS+1:2]`.
- **Latency:** lookup is 0 cycles. An update becomes visible to lookups and to `ghr` in the cycle after the edge.
- **Same-cycle lookup and update to the same index:** the lookup returns the pre-update value. There is no bypass.
- **Back-to-back updates to one entry:** each cycle advances the entry by one state. Two takens from WNT reach ST.
- **History shift:** in the cycle the update is applied, `lkp_idx` still uses the old `ghr`.
- **Counter wrap:** `br_cnt`=0xFFFFFFFF plus one update gives 0.

## Structure
- **Shared package:** add `bp_ctr_t`, a 2-bit enum {SNT, WNT, WT, ST}, and the reset constant `BP_CTR_INIT = WNT` to `rv32i_types`.
- **Sub-module:** `sat_ctr2` holds one entry: state register, next-state logic and async reset to WNT. It has inputs `en` and `taken` and output `state`. Instantiate it 2^IDX_BITS times with a generate loop, with `en = upd_valid & (upd_idx == i)`.
- **Top level:** index XOR, read mux, GHR, mispredict logic and performance counters.

## Test plan
- **Reset defaults:** hold `rst_n` low, then release. Any `lkp_pc` gives `lkp_taken`=0, `ghr`=0, `br_cnt`=0 and `mis_cnt`=0. With `lkp_pc`=0x0000_0010 and `ghr`=0, `lkp_idx`=4.
- **Saturation:** 3 taken updates to idx 4 give `lkp_taken`=1 after the first, and the entry reaches ST. Then 1 not-taken gives WT and `lkp_taken` stays 1. Then 3 more not-taken give SNT, and one extra not-taken stays SNT.
- **History and index:** 4 updates with `upd_taken` = 1,0,1,1 give `ghr`=4'b1011. Then `lkp_pc`=0x0000_0010 gives `lkp_idx` = 4 ^ 11 = 15.
- **Mispredict and counters:** `upd_pred`=1 with `upd_taken`=0 and `upd_valid`=1 gives `mispredict`=1 in the same cycle, then `br_cnt`=1 and `mis_cnt`=1. The same pattern with `upd_valid`=0 and X data changes nothing.
- **Same-index collision:** with idx 7 at WNT, `lkp_idx`=7 while a taken update goes to idx 7. `lkp_taken` is 0 that cycle and 1 the next.
- **Async reset mid-stream:** with entries trained, pulse `rst_n` low between edges while `upd_valid`=1. All outputs return to reset values without waiting for a clock edge.
